prg_loader: RTL and testbench

Hardware program loader that sits directly upstream of the 6502 memory map and CPU reset. It takes a byte stream from a host link (UART/debug bridge) over a valid/ready handshake and parses a small header. It writes the payload into the shared 64 KiB RAM write port, then hands the start address to the CPU reset vector and releases the CPU. This replaces bench-only memory preloading with a synthesizable path.

---
 rtl/prg_loader_defs.sv | 27 ++
 rtl/prg_loader.sv | 172 +++++++++++++++++
 tb/tb_prg_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prg_loader_defs.sv
// Shared definitions for the program loader: FSM state encoding,
// header size and HOLD counter width.
package prg_loader_defs;

  localparam int HDR_BYTES  = 4;
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_HOLD,
    S_DONE,
    S_ERR
  } prg_ld_state_t;

  // States in which the loader consumes stream bytes.
  function automatic logic is_stream_state(prg_ld_state_t s);
    return (s == S_ADDR_LO) || (s == S_ADDR_HI) || (s == S_LEN_LO) ||
           (s == S_LEN_HI)  || (s == S_DATA)    || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/prg_loader.sv
// Program loader: parses a little-endian {addr, len} header from a byte
// stream, writes the payload into RAM, then publishes the start address as
// the CPU reset vector and releases the CPU after a short hold.
// Optional feature: define PRG_LOADER_CHECKSUM_EN to require a trailing
// 8-bit additive checksum of the payload; a mismatch ends in ERR.
module prg_loader
  import prg_loader_defs::*;
#(
  parameter logic [15:0] RESET_VEC   = 16'h8000,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_write_en,
  output logic [15:0] pc_reset,
  output logic        cpu_run,
  output logic        busy,
  output logic        load_err
);

  typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;
  localparam hold_cnt_t HOLD_LAST = hold_cnt_t'(HOLD_CYCLES);

  prg_ld_state_t state;
  logic [7:0]    addr_lo;
  logic [7:0]    len_lo;
  logic [15:0]   wr_addr;
  logic [15:0]   remaining;
  hold_cnt_t     hold_cnt;
  logic          accept;

  // in_ready is a decode of the state register, forced low while rst is high.
  assign in_ready = ~rst & is_stream_state(state);
  assign accept   = in_valid & in_ready;

`ifdef PRG_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  // Loader FSM with its datapath registers and all registered outputs.
  // NOTE: every register here, datapath included, takes the synchronous reset so
  // a mid-load rst leaves no stale address, count or write strobe behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_lo      <= '0;
      len_lo       <= '0;
      wr_addr      <= '0;
      remaining    <= '0;
      hold_cnt     <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      pc_reset     <= RESET_VEC;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
`ifdef PRG_LOADER_CHECKSUM_EN
      csum         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; the write strobe defaults low
      // and is raised only in the cycle after a data byte is accepted.
      mem_write_en <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_start) begin
            state   <= S_ADDR_LO;
            cpu_run <= 1'b0;
            busy    <= 1'b1;
`ifdef PRG_LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_ADDR_LO: begin
          if (accept) begin
            addr_lo <= in_data;
            state   <= S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          if (accept) begin
            pc_reset <= {in_data, addr_lo};
            wr_addr  <= {in_data, addr_lo};
            state    <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            remaining <= {in_data, len_lo};
`ifdef PRG_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
            if ({in_data, len_lo} == 16'd0) begin
`ifdef PRG_LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_HOLD;
              hold_cnt <= hold_cnt_t'(1);
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_write_en <= 1'b1;
            mem_addr     <= wr_addr;
            mem_data     <= in_data;
            wr_addr      <= wr_addr + 16'd1;
            remaining    <= remaining - 16'd1;
`ifdef PRG_LOADER_CHECKSUM_EN
            csum         <= csum + in_data;
`endif
            if (remaining == 16'd1) begin
`ifdef PRG_LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              // The last write lands one cycle after entry, so count from 0.
              state    <= S_HOLD;
              hold_cnt <= '0;
`endif
            end
          end
        end
`ifdef PRG_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              state    <= S_HOLD;
              hold_cnt <= hold_cnt_t'(1);
            end else begin
              state <= S_ERR;
              busy  <= 1'b0;
              err_q <= 1'b1;
            end
          end
        end
`endif
        S_HOLD: begin
          if (hold_cnt >= HOLD_LAST) begin
            state   <= S_DONE;
            cpu_run <= 1'b1;
            busy    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + hold_cnt_t'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader: directed loads from the test plan plus
// randomized loads, all compared against a stream-level reference model.
module tb_prg_loader;
  import prg_loader_defs::*;

  localparam logic [15:0] RV = 16'h8000;
  localparam int          HC = 2;
`ifdef PRG_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write_en;
  logic [15:0] pc_reset;
  logic        cpu_run;
  logic        busy;
  logic        load_err;

  prg_loader #(.RESET_VEC(RV), .HOLD_CYCLES(HC)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_write_en (mem_write_en),
    .pc_reset     (pc_reset),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every observed RAM write, tagged with the cycle it was seen in.
  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t wr_q[$];

  always @(negedge clk)
    if (mem_write_en === 1'b1) wr_q.push_back(wr_t'{cyc, mem_addr, mem_data});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [7:0] payload[$];
  logic [7:0] stream_q[$];
  int         acc_q[$];

  // Serialize header + payload (+ checksum) into stream_q.
  task automatic build_stream(input logic [15:0] base, input bit bad_csum);
    logic [15:0] len16;
    logic [7:0]  sum;
    len16 = 16'(payload.size());
    stream_q.delete();
    stream_q.push_back(base[7:0]);
    stream_q.push_back(base[15:8]);
    stream_q.push_back(len16[7:0]);
    stream_q.push_back(len16[15:8]);
    sum = 8'h00;
    foreach (payload[i]) begin
      stream_q.push_back(payload[i]);
      sum = sum + payload[i];
    end
    if (CSUM_ON) stream_q.push_back(bad_csum ? sum + 8'd1 : sum);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Offer stream_q bytes until 'upto' are accepted; record acceptance cycles.
  task automatic feed(input int upto, input int gap_pct, input bit noise, output int got);
    int n;
    acc_q.delete();
    got = 0;
    n = 0;
    while (got < upto && n < 4000) begin
      in_valid   = ($urandom_range(99) >= gap_pct);
      in_data    = stream_q[got];
      load_start = noise && ($urandom_range(15) == 0);
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc);
        got++;
      end
      @(negedge clk);
      n++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] base, input int gap_pct, input bit bad_csum);
    int len, nw0, got, n, last, exp_done, ready_in_hold;
    bit exp_err;
    len     = payload.size();
    exp_err = bad_csum && CSUM_ON;
    build_stream(base, bad_csum);
    nw0 = wr_q.size();
    pulse_start();
    check("busy_start", busy, 1);
    check("err_clear", load_err, 0);
    check("run_clear", cpu_run, 0);
    feed(stream_q.size(), gap_pct, 1'b1, got);
    check("stream_accepted", got, stream_q.size());
    if (got != stream_q.size()) return;

    last = acc_q[acc_q.size()-1];
    if (exp_err)                    exp_done = last + 1;
    else if (len > 0 && !CSUM_ON)   exp_done = last + 2 + HC;
    else                            exp_done = last + 1 + HC;

    n = 0;
    ready_in_hold = 0;
    while (!(cpu_run || load_err) && n < 200) begin
      if (in_ready) ready_in_hold++;
      @(negedge clk);
      n++;
    end
    check("done_seen", cpu_run | load_err, 1);
    check("done_cycle", cyc, exp_done);
    check("in_ready_hold", ready_in_hold, 0);
    check("cpu_run", cpu_run, !exp_err);
    check("load_err", load_err, exp_err);
    check("busy_end", busy, 0);
    check("in_ready_end", in_ready, 0);
    check("pc_reset", pc_reset, base);
    check("wr_count", wr_q.size() - nw0, len);
    for (int i = 0; i < len && nw0 + i < wr_q.size(); i++) begin
      check("wr_addr", wr_q[nw0+i].addr, 16'(base + i));
      check("wr_data", wr_q[nw0+i].data, payload[i]);
      check("wr_cycle", wr_q[nw0+i].cyc, acc_q[HDR_BYTES+i] + 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_mem_we"}, mem_write_en, 0);
    check({tag, "_pc_reset"}, pc_reset, RV);
    check({tag, "_cpu_run"}, cpu_run, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_load_err"}, load_err, 0);
  endtask

  // rst after 2 of 4 data bytes: exactly two writes, then reset values.
  task automatic reset_mid_load();
    int nw0, got;
    payload.delete();
    payload.push_back(8'hA1); payload.push_back(8'hB2);
    payload.push_back(8'hC3); payload.push_back(8'hD4);
    build_stream(16'h4000, 1'b0);
    nw0 = wr_q.size();
    pulse_start();
    feed(HDR_BYTES + 2, 0, 1'b0, got);
    check("rst_fed", got, HDR_BYTES + 2);
    rst = 1'b1;
    #1;
    check("rst_in_ready_now", in_ready, 0);
    @(negedge clk);
    check_reset_values("rst_mid");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_wr_count", wr_q.size() - nw0, 2);
    for (int i = 0; i < 2 && nw0 + i < wr_q.size(); i++) begin
      check("rst_wr_addr", wr_q[nw0+i].addr, 16'h4000 + 16'(i));
      check("rst_wr_data", wr_q[nw0+i].data, payload[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("por");

    payload.delete();
    payload.push_back(8'h11); payload.push_back(8'h22);
    payload.push_back(8'h33); payload.push_back(8'h44);
    run_load(16'h8000, 0, 1'b0);
    run_load(16'hFFFE, 0, 1'b0);
    run_load(16'h8000, 50, 1'b0);

    payload.delete();
    run_load(16'hC000, 0, 1'b0);

`ifdef PRG_LOADER_CHECKSUM_EN
    payload.push_back(8'h01); payload.push_back(8'h02); payload.push_back(8'h03);
    run_load(16'h0200, 0, 1'b0);
    run_load(16'h0200, 0, 1'b1);
    run_load(16'h0300, 0, 1'b0);
`endif

    reset_mid_load();

    repeat (25) begin
      logic [15:0] base;
      int len;
      len = $urandom_range(0, 10);
      payload.delete();
      repeat (len) payload.push_back(8'($urandom));
      if ($urandom_range(3) == 0) base = 16'($urandom_range(16'hFFF8, 16'hFFFF));
      else                        base = 16'($urandom);
      run_load(base, $urandom_range(0, 60), $urandom_range(3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
